// File: rtl/aes_round_ctrl_if.sv
// Host/core control bundle for the iterative AES round sequencer.
// The sequencer takes the master side; the host/core side takes the slave side.
interface aes_round_ctrl_if #(
   parameter int RND_W = 4
);
   logic             start;
   logic             ready;
   logic             busy;
   logic             done;
   logic             accept;
   logic [RND_W-1:0] rnd_no;
   logic             enb_sb;
   logic             enb_sr;
   logic             enb_mc;
   logic             enb_ar;
   logic             enb_ks;

   modport master (
      input  start,
      output ready, busy, done, accept, rnd_no,
      output enb_sb, enb_sr, enb_mc, enb_ar, enb_ks
   );

   modport slave (
      output start,
      input  ready, busy, done, accept, rnd_no,
      input  enb_sb, enb_sr, enb_mc, enb_ar, enb_ks
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// One-round-per-clock sequencer for an iterative AES-128 core.
// Every output is a Moore decode of the state and round counter, so start never reaches an output combinationally.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int RND_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   aes_round_ctrl_if.master        bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      DONE
   } state_t;

   localparam logic [RND_W-1:0] LAST_FULL = RND_W'(NUM_ROUNDS - 1);
   localparam logic [RND_W-1:0] FINAL_RND = RND_W'(NUM_ROUNDS);

   state_t           stateReg, stateNext;
   logic [RND_W-1:0] cntReg, cntNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= IDLE;
         cntReg   <= '0;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      unique case (stateReg)
         IDLE: begin
            cntNext = '0;
            if (bus.start) stateNext = LOAD;
         end
         LOAD: begin
            stateNext = ROUND;
            cntNext   = RND_W'(1);
         end
         ROUND: begin
            if (cntReg == LAST_FULL) begin
               stateNext = FINAL;
               cntNext   = FINAL_RND;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         FINAL: begin
            stateNext = DONE;
         end
         DONE: begin
            // Back-to-back start goes straight to LOAD without an idle bubble.
            cntNext   = '0;
            stateNext = bus.start ? LOAD : IDLE;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_comb begin
      bus.ready  = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.accept = 1'b0;
      bus.rnd_no = cntReg;
      bus.enb_sb = 1'b0;
      bus.enb_sr = 1'b0;
      bus.enb_mc = 1'b0;
      bus.enb_ar = 1'b0;
      bus.enb_ks = 1'b0;
      unique case (stateReg)
         IDLE: begin
            bus.ready = 1'b1;
         end
         LOAD: begin
            bus.busy   = 1'b1;
            bus.accept = 1'b1;
            bus.enb_ar = 1'b1;
         end
         ROUND: begin
            bus.busy   = 1'b1;
            bus.enb_sb = 1'b1;
            bus.enb_sr = 1'b1;
            bus.enb_mc = 1'b1;
            bus.enb_ar = 1'b1;
            bus.enb_ks = 1'b1;
         end
         FINAL: begin
            // The last AES round skips MixColumns.
            bus.busy   = 1'b1;
            bus.enb_sb = 1'b1;
            bus.enb_sr = 1'b1;
            bus.enb_ar = 1'b1;
            bus.enb_ks = 1'b1;
         end
         DONE: begin
            bus.ready = 1'b1;
            bus.done  = 1'b1;
         end
         default: begin
            bus.ready = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the iterative AES-128 encryption core: one round per clock.
- Generates the core's control inputs: accept, rndNo, and the per-stage enables for SubBytes, ShiftRows, MixColumns, AddRoundKey and KeySchedule.
- Gives the host a start/busy/done handshake.
- Sits between the testbench/host and the core. The core's cipher_text register holds the result when done is high.

Parameters:
- NUM_ROUNDS, 10, number of full AES rounds after the initial AddRoundKey (10 for AES-128; legal range 2..15).
- RND_W, 4, width of rnd_no; must hold NUM_ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request an encryption; sampled only when ready=1.
- ready  out  1  controller can accept start (IDLE or DONE state).
- busy  out  1  encryption in progress (LOAD, ROUND or FINAL state).
- done  out  1  one-cycle pulse; core cipher_text is valid this cycle.
- accept  out  1  core loads plain_text/cipher_key instead of its feedback registers.
- rnd_no  out  RND_W  current round number to the core.
- enb_sb  out  1  SubBytes enable.
- enb_sr  out  1  ShiftRows enable.
- enb_mc  out  1  MixColumns enable.
- enb_ar  out  1  AddRoundKey enable.
- enb_ks  out  1  KeySchedule enable.

Behaviour:
- Reset and clock: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, round counter=0, ready=1, busy=0, done=0, accept=0, rnd_no=0, all enb_*=0.
- Output timing: Moore outputs, decoded only from registered state and round counter. No combinational path from start to any output.
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - All enables 0, accept 0. The core's disabled stages pass through, so it recirculates and holds cipher_text and round_key.
  - start=1 -> LOAD.
- LOAD (round 0):
  - accept=1, rnd_no=0, enb_ar=1; enb_sb=enb_sr=enb_mc=enb_ks=0.
  - Core captures plaintext XOR key.
  - plain_text/cipher_key need only be stable during this cycle.
  - Next state: ROUND, counter=1.
- ROUND (rounds 1..NUM_ROUNDS-1):
  - accept=0, rnd_no=counter, all five enables 1.
  - Counter increments each cycle.
  - When counter=NUM_ROUNDS-1 -> FINAL, counter=NUM_ROUNDS.
- FINAL:
  - rnd_no=NUM_ROUNDS, enb_sb=enb_sr=enb_ar=enb_ks=1, enb_mc=0.
  - Next state: DONE.
- DONE:
  - done=1, ready=1, busy=0, all enables 0 (core holds result).
  - start=1 -> LOAD (back-to-back; no idle bubble). Otherwise -> IDLE.
- Latency: start sampled at edge E0 -> LOAD in cycle after E0 -> ciphertext captured at edge E(NUM_ROUNDS+1) -> done high in the cycle following that edge. For default: done is high in the 12th cycle counting the LOAD cycle as the 1st.
- Throughput: one block per NUM_ROUNDS+2 cycles with start held high.
- start while busy=1: ignored, not queued.
- start held high continuously: a new encryption starts from every DONE.
- rst=1 mid-operation:
  - Next edge forces the reset values, discarding the operation; no done pulse.
  - rst takes priority over start in the same cycle.
- Counter: RND_W bits, never wraps. It is cleared on entry to LOAD and when in IDLE.
- Invariant: accept=1 only in LOAD.
- Invariant: exactly one of {ready, busy} is 1 in every cycle.
- Invariant: done implies ready.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, single start pulse.
  - Required: done high in the 12th cycle after LOAD begins; cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a.
- Control trace:
  - Stimulus: same run, logging controls per cycle.
  - Required: rnd_no sequence 0,1..9,10.
  - Required: accept=1 only in cycle 1.
  - Required: enb_mc=0 in cycles 1 and 11, 1 in cycles 2..10.
  - Required: enb_ks=0 only in cycle 1.
- Back-to-back:
  - Stimulus: start held high for two blocks (FIPS-197 C.1 vector, then all-zero key/pt).
  - Required: second LOAD directly follows DONE; second result 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Required: two done pulses exactly 12 cycles apart.
- Start during busy:
  - Stimulus: pulse start at round 5.
  - Required: ignored; rnd_no continues 6..10; exactly one done; no extra LOAD.
- Reset mid-operation:
  - Stimulus: assert rst during round 4.
  - Required: next cycle state IDLE, ready=1, all enables 0, no done pulse.
  - Required: a fresh start then yields the correct C.1 result.
- Idle hold:
  - Stimulus: after done, hold start=0 for 20 cycles.
  - Required: cipher_text unchanged; enables and accept stay 0; done not reasserted.
